// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector family: FSM state encoding and
// default datapath widths.
package seq_det_pkg;

  localparam int WIN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_hit_window_counter_if.sv
// Detector-side control/status bundle for the hit window counter.
interface seq_hit_window_counter_if
  import seq_det_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             en;
  logic             hit;
  logic             start;
  logic             cont;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] thresh;
  logic             clr;
  logic [CNT_W-1:0] count_out;
  logic             count_valid;
  logic             alarm;
  logic             busy;

  modport master (
    output en, hit, start, cont, win_len, thresh, clr,
    input  count_out, count_valid, alarm, busy
  );

  modport slave (
    input  en, hit, start, cont, win_len, thresh, clr,
    output count_out, count_valid, alarm, busy
  );

endinterface

// File: rtl/seq_hit_window_counter_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_hit_window_counter.sv
// Counts detector hits over a programmable window of bit-times, reports each
// window total with a one-cycle pulse and raises a sticky threshold alarm.
module seq_hit_window_counter
  import seq_det_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  seq_hit_window_counter_if.slave  bus
);

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             count_valid_q, count_valid_d;
  logic             alarm_q, alarm_d;

  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] total;
  logic             hit_clr;
  logic             hit_inc;
  logic             win_end;

  assign win_end = (state_q == ST_RUN) && bus.en && (bit_cnt_q == (win_q - WIN_ONE));
  assign hit_inc = (state_q == ST_RUN) && bus.en && bus.hit;
  // Zeroing at window end lets a continuous window start counting on the very next bit.
  assign hit_clr = bus.clr || (state_q == ST_IDLE) || win_end;

  // The last-bit hit has not reached the counter yet, so fold it in here.
  assign total = (bus.hit && (hit_cnt != CNT_MAX)) ? (hit_cnt + CNT_ONE) : hit_cnt;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (hit_clr),
    .inc_i (hit_inc),
    .cnt_o (hit_cnt)
  );

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    win_d         = win_q;
    thr_d         = thr_q;
    count_out_d   = count_out_q;
    count_valid_d = 1'b0;
    alarm_d       = alarm_q;

    if (bus.clr) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      alarm_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = '0;
          if (bus.start && (bus.win_len != '0)) begin
            win_d   = bus.win_len;
            thr_d   = bus.thresh;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (win_end) begin
            bit_cnt_d     = '0;
            count_out_d   = total;
            count_valid_d = 1'b1;
            if ((thr_q != '0) && (total >= thr_q)) begin
              alarm_d = 1'b1;
            end
            if (!bus.cont) begin
              state_d = ST_IDLE;
            end
          end else if (bus.en) begin
            bit_cnt_d = bit_cnt_q + WIN_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      win_q         <= '0;
      thr_q         <= '0;
      count_out_q   <= '0;
      count_valid_q <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      win_q         <= win_d;
      thr_q         <= thr_d;
      count_out_q   <= count_out_d;
      count_valid_q <= count_valid_d;
      alarm_q       <= alarm_d;
    end
  end

  assign bus.count_out   = count_out_q;
  assign bus.count_valid = count_valid_q;
  assign bus.alarm       = alarm_q;
  assign bus.busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_seq_hit_window_counter.sv
// Scoreboard bench: directed scenarios then random traffic against a
// bit-counting reference model of the window counter.
module tb_seq_hit_window_counter;

  localparam int WIN_W   = 5;
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_hit_window_counter_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

  seq_hit_window_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int windows_seen = 0;
  bit chk_en = 1'b0;

  // Reference model: plain integers counting bits seen and hits seen.
  int m_run = 0, m_bits = 0, m_hits = 0, m_len = 0, m_thr = 0;
  int nxt_busy = 0, nxt_alarm = 0, nxt_count = 0, nxt_valid = 0;
  int cur_busy = 0, cur_alarm = 0, cur_count = 0, cur_valid = 0;

  int q_cnt[$];
  int q_al[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(bus.busy), cur_busy);
      check("alarm", int'(bus.alarm), cur_alarm);
      check("count_out", int'(bus.count_out), cur_count);
      check("count_valid", int'(bus.count_valid), cur_valid);
      if (bus.count_valid) begin
        if (q_cnt.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          windows_seen++;
          check("sb_count", int'(bus.count_out), q_cnt.pop_front());
          check("sb_alarm", int'(bus.alarm), q_al.pop_front());
          $display("window %0d: count_out=%0d alarm=%0d", windows_seen, bus.count_out, bus.alarm);
        end
      end
    end
  end

  task automatic apply(input bit r, input bit e, input bit h, input bit s, input bit c,
                       input int wl, input int th, input bit cl);
    int total;
    rst         = r;
    bus.en      = e;
    bus.hit     = h;
    bus.start   = s;
    bus.cont    = c;
    bus.win_len = WIN_W'(wl);
    bus.thresh  = CNT_W'(th);
    bus.clr     = cl;
    nxt_valid = 0;
    if (r) begin
      m_run = 0; m_bits = 0; m_hits = 0; m_len = 0; m_thr = 0;
      nxt_alarm = 0; nxt_count = 0;
    end else if (cl) begin
      m_run = 0;
      nxt_alarm = 0;
    end else if (m_run == 0) begin
      if (s && wl != 0) begin
        m_run = 1; m_len = wl; m_thr = th; m_bits = 0; m_hits = 0;
      end
    end else if (e) begin
      m_bits++;
      if (h && m_hits < CNT_MAX) m_hits++;
      if (m_bits == m_len) begin
        total = m_hits;
        nxt_count = total;
        nxt_valid = 1;
        if (m_thr != 0 && total >= m_thr) nxt_alarm = 1;
        q_cnt.push_back(total);
        q_al.push_back(nxt_alarm);
        m_bits = 0;
        m_hits = 0;
        if (!c) m_run = 0;
      end
    end
    nxt_busy = m_run;
  endtask

  task automatic step(input bit r, input bit e, input bit h, input bit s, input bit c,
                      input int wl, input int th, input bit cl);
    @(posedge clk);
    #1;
    cur_busy  = nxt_busy;
    cur_alarm = nxt_alarm;
    cur_count = nxt_count;
    cur_valid = nxt_valid;
    chk_en    = 1'b1;
    apply(r, e, h, s, c, wl, th, cl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Basic count: hits on bits 3 and 7 of an 8-bit window.
    step(0, 0, 0, 1, 0, 8, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, (i == 3 || i == 7), 0, 0, 0, 0, 0);
    idle(3);

    // Hit only on the last bit sets the alarm; it survives an empty window.
    step(0, 0, 0, 1, 0, 4, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, (i == 3), 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0, 4, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Saturation: 20 hits into a 3-bit counter.
    step(0, 0, 0, 1, 0, 20, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Continuous mode with en every other cycle; hits on bits 0, 4, 5.
    step(0, 0, 0, 1, 1, 3, 0, 0);
    for (int i = 0; i < 12; i++) begin
      int b;
      b = i / 2;
      step(0, (i % 2 == 0), (b == 0 || b == 4 || b == 5), 0, (i < 10), 0, 0, 0);
    end
    idle(3);

    // Abort by clr after 5 bits, then a zero-length start is ignored.
    step(0, 0, 0, 1, 0, 10, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    idle(3);

    // clr and start together: start dropped.
    step(0, 0, 0, 1, 0, 3, 0, 1);
    idle(2);

    // Reset mid-window, then a normal length-2 window with alarm.
    step(0, 0, 0, 1, 0, 6, 2, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0, 2, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, 0, 0, 0);
    idle(3);

    // Window length 1 in continuous mode: a report after every bit.
    step(0, 0, 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, (i != 2), (i % 2 == 0), 0, (i < 5), 0, 0, 0);
    idle(3);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit r, e, h, s, c, cl;
      int wl, th;
      r  = ($urandom_range(0, 299) == 0);
      cl = ($urandom_range(0, 79) == 0);
      e  = ($urandom_range(0, 9) < 7);
      h  = ($urandom_range(0, 9) < 4);
      s  = ($urandom_range(0, 5) == 0);
      c  = ($urandom_range(0, 1) == 1);
      wl = ($urandom_range(0, 15) == 0) ? ((1 << WIN_W) - 1) : int'($urandom_range(0, 12));
      th = int'($urandom_range(0, CNT_MAX));
      step(r, e, h, s, c, wl, th, cl);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);

    check("queue_drained", q_cnt.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
